cronometro_0a99: RTL and testbench
==================================

Name: cronometro_0a99

Overview:
- Seconds counter 0..LIMIT with start/pause and clear buttons; produces the 7-bit `valor` consumed by the two-digit 7-segment display stage.
- Sits directly upstream of the display decoder and drives its `valor` input.
- Contains:
  - button conditioning (synchroniser, optional debounce, rising-edge pulse);
  - a tick prescaler;
  - a 4-state control FSM.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per count tick (1 Hz at 50 MHz); must be ≥2.
- LIMIT, 99: final count value; range 1..99.
- DEB_CYCLES, 1_000_000: stable cycles required to accept a button level (used only with DEBOUNCE_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- btn_start  in  1  start/pause button; active-high; asynchronous to clk.
- btn_clear  in  1  clear button; active-high; asynchronous to clk.
- valor  out  7  current count 0..LIMIT; feeds the display stage.
- rodando  out  1  high while in RUNNING.
- fim  out  1  high while in FINISHED.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, valor=0, rodando=0, fim=0;
  - prescaler=0;
  - all sync, debounce and edge registers=0.
  - Reset asserted mid-count aborts immediately. No counting resumes after release until a new start.
- Button path, per button:
  - 2-FF synchroniser → (optional debounce) → edge register.
  - Output is a 1-cycle pulse on each accepted 0→1 transition.
  - Without debounce: pulse is registered 3 clk after the input rises.
  - Holding a button generates exactly one pulse.
- FSM states: IDLE, RUNNING, PAUSED, FINISHED.
  - IDLE + start_p → RUNNING, with prescaler=0.
  - RUNNING + start_p → PAUSED.
  - PAUSED + start_p → RUNNING. Prescaler keeps its partial value, so the fraction of a second is preserved.
  - FINISHED + start_p → ignored.
  - Any state + clear_p → IDLE, with valor=0 and prescaler=0.
  - clear_p has priority over start_p in the same cycle.
- Prescaler:
  - Increments only in RUNNING and holds in all other states.
  - When it equals TICK_DIV-1, tick=1 for that cycle and the prescaler returns to 0.
- Count:
  - On tick in RUNNING: valor <= valor+1, visible the cycle after the tick.
  - If the tick takes valor from LIMIT-1 to LIMIT, state → FINISHED in the same edge. valor then holds at LIMIT and never wraps.
- Simultaneous events:
  - tick + start_p in RUNNING: the increment is applied and state → PAUSED.
  - tick + clear_p: clear wins (valor=0).
- Outputs:
  - rodando and fim are registered, decoded from the next state, so they are cycle-aligned with valor.
  - valor never exceeds LIMIT; bit width is fixed at 7.

Optional Feature:
- Macro: CRONOMETRO_DEBOUNCE_EN.
- Defined:
  - The synchronised level must stay constant for DEB_CYCLES consecutive clk before the filtered level changes.
  - The edge pulse comes 1 clk after acceptance.
  - Glitches shorter than DEB_CYCLES produce no pulse.
- Undefined:
  - The synchronised level feeds the edge detector directly; no counter logic is synthesised.
  - DEB_CYCLES is unused.

Decomposition:
- Shared package/include file holds:
  - FSM state encoding (IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2, FINISHED=2'd3);
  - VALOR_MAX=99;
  - VALOR_W=7.
- One sub-module: botao_pulso (sync + optional debounce + rising-edge pulse), instantiated twice.

Test Plan:
All scenarios use TICK_DIV=4, LIMIT=5 and DEB_CYCLES=3 with debounce enabled, unless stated otherwise.
- Start count: pulse btn_start from IDLE → rodando=1; valor steps 0→1→2 every 4 clk; the first increment comes 4 clk after entering RUNNING.
- Pause preserves fraction: pause with prescaler=2 at valor=2 → valor holds 2 for 20 clk; after resume, the next increment comes 2 clk later.
- Limit: run to valor=5 → fim=1, rodando=0, valor stays 5. A further btn_start changes nothing; btn_clear → valor=0, state IDLE, fim=0.
- Simultaneous: btn_clear and btn_start accepted in the same cycle while RUNNING at valor=3 → IDLE, valor=0. Start pulse coinciding with a tick at valor=1 → valor=2, state PAUSED.
- Reset mid-run: drive reset=0 asynchronously at valor=3 between clk edges → all outputs 0 immediately; after release, valor stays 0 with no button pressed.
- Debounce:
  - With macro: a 2-cycle btn_start glitch gives no state change; a 3-cycle-stable press gives exactly one pulse.
  - Without macro: a 1-cycle synchronous pulse gives exactly one start.

Source files
------------

// File: rtl/cronometro_0a99_pkg.sv
// Shared types and limits for the cronometro_0a99 seconds counter.
package cronometro_0a99_pkg;

  localparam int VALOR_MAX = 99;
  localparam int VALOR_W   = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    PAUSED   = 2'd2,
    FINISHED = 2'd3
  } estado_t;

endpackage

// File: rtl/cronometro_0a99_botao_pulso.sv
// Button conditioner: 2-FF synchroniser, debounce filter when CRONOMETRO_DEBOUNCE_EN
// is defined, then a registered one-cycle pulse on each accepted rising level.
module botao_pulso #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulso
);

  if (DEB_CYCLES < 1) begin : g_chk_deb
    $error("botao_pulso: DEB_CYCLES must be at least 1");
  end

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulso;
  logic w_nivel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef CRONOMETRO_DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_filt;

  // The filtered level flips only after DEB_CYCLES consecutive samples disagree with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (r_sync2 == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
      r_filt <= r_sync2;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_nivel = r_filt;
`else
  assign w_nivel = r_sync2;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev  <= 1'b0;
      r_pulso <= 1'b0;
    end else begin
      r_prev  <= w_nivel;
      r_pulso <= w_nivel & ~r_prev;
    end
  end

  assign o_pulso = r_pulso;

endmodule

// File: rtl/cronometro_0a99.sv
// Start/pause/clear seconds counter 0..LIMIT feeding the 7-segment display stage.
// Button debounce is compiled in only when CRONOMETRO_DEBOUNCE_EN is defined.
module cronometro_0a99
  import cronometro_0a99_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int LIMIT      = VALOR_MAX,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_start,
  input  logic               btn_clear,
  output logic [VALOR_W-1:0] valor,
  output logic               rodando,
  output logic               fim
);

  if (TICK_DIV < 2) begin : g_chk_div
    $error("cronometro_0a99: TICK_DIV must be at least 2");
  end
  if (LIMIT < 1 || LIMIT > VALOR_MAX) begin : g_chk_lim
    $error("cronometro_0a99: LIMIT out of range 1..99");
  end

  localparam int PW = $clog2(TICK_DIV);

  logic w_start_p;
  logic w_clear_p;
  logic w_tick;

  estado_t            r_estado;
  estado_t            w_estado_nx;
  logic [PW-1:0]      r_presc;
  logic [PW-1:0]      w_presc_nx;
  logic [VALOR_W-1:0] r_valor;
  logic [VALOR_W-1:0] w_valor_nx;
  logic               r_rodando;
  logic               r_fim;

  botao_pulso #(.DEB_CYCLES(DEB_CYCLES)) u_btn_start (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_btn   (btn_start),
    .o_pulso (w_start_p)
  );

  botao_pulso #(.DEB_CYCLES(DEB_CYCLES)) u_btn_clear (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_btn   (btn_clear),
    .o_pulso (w_clear_p)
  );

  assign w_tick = (r_estado == RUNNING) && (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado  <= IDLE;
      r_presc   <= '0;
      r_valor   <= '0;
      r_rodando <= 1'b0;
      r_fim     <= 1'b0;
    end else begin
      r_estado  <= w_estado_nx;
      r_presc   <= w_presc_nx;
      r_valor   <= w_valor_nx;
      r_rodando <= (w_estado_nx == RUNNING);
      r_fim     <= (w_estado_nx == FINISHED);
    end
  end

  always_comb begin
    w_estado_nx = r_estado;
    w_presc_nx  = r_presc;
    w_valor_nx  = r_valor;

    if (r_estado == RUNNING) begin
      w_presc_nx = w_tick ? '0 : r_presc + 1'b1;
    end

    if (w_tick) begin
      w_valor_nx = r_valor + 1'b1;
      if (r_valor == VALOR_W'(LIMIT - 1)) begin
        w_estado_nx = FINISHED;
      end
    end

    // Clear overrides both the tick and a simultaneous start.
    if (w_clear_p) begin
      w_estado_nx = IDLE;
      w_valor_nx  = '0;
      w_presc_nx  = '0;
    end else if (w_start_p) begin
      case (r_estado)
        IDLE: begin
          w_estado_nx = RUNNING;
          w_presc_nx  = '0;
        end
        RUNNING: begin
          if (w_estado_nx != FINISHED) begin
            w_estado_nx = PAUSED;
          end
        end
        PAUSED:   w_estado_nx = RUNNING;
        default:  w_estado_nx = r_estado;
      endcase
    end
  end

  assign valor   = r_valor;
  assign rodando = r_rodando;
  assign fim     = r_fim;

endmodule

// File: tb/tb_cronometro_0a99.sv
// Directed bench for cronometro_0a99 with TICK_DIV=4, LIMIT=5, DEB_CYCLES=3.
`timescale 1ns/1ps
module tb_cronometro_0a99;

  localparam int TD  = 4;
  localparam int LIM = 5;
  localparam int DEB = 3;
`ifdef CRONOMETRO_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 4;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start = 1'b0;
  logic       btn_clear = 1'b0;
  logic [6:0] valor;
  logic       rodando;
  logic       fim;

  cronometro_0a99 #(.TICK_DIV(TD), .LIMIT(LIM), .DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .valor     (valor),
    .rodando   (rodando),
    .fim       (fim)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         when;
    logic [6:0] v;
    logic       r;
    logic       f;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t e_cur;
  int   errs   = 0;
  int   checks = 0;

  task automatic expect_at(input int when, input int v, input logic r, input logic f, input string tag);
    exp_t e;
    int   i;
    e.when = when; e.v = 7'(v); e.r = r; e.f = f; e.tag = tag;
    i = 0;
    while (i < sb.size() && sb[i].when <= when) i++;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].when <= cyc) begin
      e_cur = sb.pop_front();
      checks++;
      if (e_cur.when < cyc) begin
        errs++;
        $error("FAIL %s: check for cycle %0d missed at cycle %0d", e_cur.tag, e_cur.when, cyc);
      end else begin
        assert ({valor, rodando, fim} === {e_cur.v, e_cur.r, e_cur.f}) else begin
          errs++;
          $error("FAIL %s: got valor=%0d rodando=%b fim=%b, expected valor=%0d rodando=%b fim=%b",
                 e_cur.tag, valor, rodando, fim, e_cur.v, e_cur.r, e_cur.f);
        end
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic press(input logic s, input logic c, input int hold);
    btn_start = s;
    btn_clear = c;
    repeat (hold) @(negedge clk);
    btn_start = 1'b0;
    btn_clear = 1'b0;
  endtask

  int t, r, e, e2, a, d, k, rr, g, h;

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    assert ({valor, rodando, fim} === 9'd0) else begin
      errs++;
      $error("FAIL reset_state: got valor=%0d rodando=%b fim=%b, expected all 0", valor, rodando, fim);
    end
    reset = 1'b1;
    @(negedge clk);

    // Start and first two ticks
    t = cyc + LAT;
    expect_at(t - 1, 0, 0, 0, "idle_before_start");
    expect_at(t,     0, 1, 0, "run_entry");
    expect_at(t + 3, 0, 1, 0, "no_early_tick");
    expect_at(t + 4, 1, 1, 0, "tick1");
    expect_at(t + 7, 1, 1, 0, "hold1");
    expect_at(t + 8, 2, 1, 0, "tick2");
    expect_at(t + 9, 2, 1, 0, "before_pause");
    press(1'b1, 1'b0, 3);

    // Pause with prescaler at 2, hold 20 clk, resume: increment 2 clk later
    wait_cyc(t + 10 - LAT);
    expect_at(t + 10, 2, 0, 0, "paused");
    expect_at(t + 30, 2, 0, 0, "pause_hold");
    press(1'b1, 1'b0, 3);
    r = t + 31;
    wait_cyc(r - LAT);
    expect_at(r,      2, 1, 0, "resume");
    expect_at(r + 1,  2, 1, 0, "resume_frac");
    expect_at(r + 2,  3, 1, 0, "tick3_after_resume");
    expect_at(r + 6,  4, 1, 0, "tick4");
    expect_at(r + 9,  4, 1, 0, "before_limit");
    expect_at(r + 10, 5, 0, 1, "finished");
    expect_at(r + 14, 5, 0, 1, "hold_limit");
    press(1'b1, 1'b0, 3);

    // Start in FINISHED is ignored, clear returns to IDLE
    wait_cyc(r + 11);
    e = r + 11 + LAT;
    expect_at(e + 2, 5, 0, 1, "start_in_finished");
    press(1'b1, 1'b0, 3);
    wait_cyc(e + 3);
    e2 = cyc + LAT;
    expect_at(e2 - 1, 5, 0, 1, "before_clear");
    expect_at(e2,     0, 0, 0, "clear_from_finished");
    expect_at(e2 + 5, 0, 0, 0, "idle_after_clear");
    press(1'b0, 1'b1, 3);

    // Clear and start together at valor=3
    wait_cyc(e2 + 6);
    a = cyc + LAT;
    expect_at(a, 0, 1, 0, "run_entry2");
    press(1'b1, 1'b0, 3);
    wait_cyc(a + 13 - LAT);
    expect_at(a + 12, 3, 1, 0, "at_three");
    expect_at(a + 13, 0, 0, 0, "clear_beats_start");
    expect_at(a + 20, 0, 0, 0, "idle_after_both");
    press(1'b1, 1'b1, 3);

    // Start coinciding with a tick at valor=1
    wait_cyc(a + 22);
    d = cyc + LAT;
    expect_at(d,     0, 1, 0, "run_entry3");
    expect_at(d + 4, 1, 1, 0, "tick_to_one");
    press(1'b1, 1'b0, 3);
    wait_cyc(d + 8 - LAT);
    expect_at(d + 7,  1, 1, 0, "before_tick_pause");
    expect_at(d + 8,  2, 0, 0, "tick_and_pause");
    expect_at(d + 15, 2, 0, 0, "paused_after_tick");
    press(1'b1, 1'b0, 3);
    wait_cyc(d + 16);
    k = cyc + LAT;
    expect_at(k, 0, 0, 0, "clear_from_paused");
    press(1'b0, 1'b1, 3);

    // Asynchronous reset mid-run at valor=3
    wait_cyc(k + 2);
    rr = cyc + LAT;
    expect_at(rr + 12, 3, 1, 0, "pre_reset");
    press(1'b1, 1'b0, 3);
    wait_cyc(rr + 13);
    #2 reset = 1'b0;
    #1;
    checks++;
    assert ({valor, rodando, fim} === 9'd0) else begin
      errs++;
      $error("FAIL async_reset: got valor=%0d rodando=%b fim=%b, expected all 0", valor, rodando, fim);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    expect_at(cyc + 5,  0, 0, 0, "post_reset_early");
    expect_at(cyc + 20, 0, 0, 0, "post_reset_late");
    wait_cyc(cyc + 21);

`ifdef CRONOMETRO_DEBOUNCE_EN
    g = cyc;
    expect_at(g + 12, 0, 0, 0, "glitch_ignored");
    press(1'b1, 1'b0, 2);
    wait_cyc(g + 14);
    h = cyc + LAT;
    press(1'b1, 1'b0, 3);
`else
    h = cyc + LAT;
    press(1'b1, 1'b0, 1);
`endif
    expect_at(h,     0, 1, 0, "single_press_start");
    expect_at(h + 4, 1, 1, 0, "single_press_tick");
    expect_at(h + 9, 2, 1, 0, "no_second_pulse");

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errs++;
      $display("FAIL drain: %0d expected results never compared, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
